// File: rtl/connect_four_move_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : connect_four_move_ctrl_if
// Description : Board-storage and win-checker bus for the Connect Four move
//               controller.
//               master : the move controller (board read/write, check start)
//               slave  : board storage and win checker
//   rd_row/rd_col  board read address (master -> slave)
//   rd_data        cell at read address, same-cycle (slave -> master)
//   wr_en          one-cycle write strobe; wr_row/wr_col/wr_data write payload
//   chk_start      one-cycle pulse starting a win check at (wr_row, wr_col)
//   chk_done       checker finished; chk_win valid alongside it
// Revision    : 1.0 - initial release
// ============================================================================
interface connect_four_move_ctrl_if;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [1:0] rd_data;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [1:0] wr_data;
  logic       chk_start;
  logic       chk_done;
  logic       chk_win;

  modport master (
    output rd_row, rd_col, wr_en, wr_row, wr_col, wr_data, chk_start,
    input  rd_data, chk_done, chk_win
  );

  modport slave (
    input  rd_row, rd_col, wr_en, wr_row, wr_col, wr_data, chk_start,
    output rd_data, chk_done, chk_win
  );
endinterface
`default_nettype wire

// File: rtl/connect_four_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : connect_four_move_ctrl
// Description : Game-sequencing controller for the Connect Four datapath.
//               Conditions the three raw buttons (synchronise, debounce,
//               edge-detect), moves the cursor, finds the lowest empty cell
//               in the cursor column, writes the current player's piece,
//               runs the external win checker and tracks player/winner.
// Ports       :
//   clk_25MHz        system clock
//   rst_n            asynchronous active-low reset
//   move_right/left  raw cursor buttons, active high, asynchronous
//   drop_piece       raw drop button, active high, asynchronous
//   bus              board/checker bus (master side)
//   current_col      cursor column
//   current_player   01 player 1, 10 player 2
//   game_over        game finished (win or draw)
//   winner           00 none/draw, 01 P1, 10 P2
//   busy             high whenever the sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module connect_four_move_ctrl #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  wire logic                clk_25MHz,
  input  wire logic                rst_n,
  input  wire logic                move_right,
  input  wire logic                move_left,
  input  wire logic                drop_piece,
  connect_four_move_ctrl_if.master bus,
  output logic [2:0]               current_col,
  output logic [1:0]               current_player,
  output logic                     game_over,
  output logic [1:0]               winner,
  output logic                     busy
);

  localparam int               c_DB_W     = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [6:0]       c_CELLS    = 7'(ROWS * COLS);
  localparam logic [2:0]       c_LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0]       c_LAST_COL = 3'(COLS - 1);
  localparam logic [1:0]       c_P1       = 2'b01;
  localparam logic [1:0]       c_P2       = 2'b10;

  // Button index: 0 right, 1 left, 2 drop.
  logic [2:0] w_btn_raw;
  logic [2:0] w_press;

  assign w_btn_raw = {drop_piece, move_left, move_right};

  // --------------------------------------------------------------------------
  // Button conditioning. The counter only runs while the synchronised sample
  // differs from the accepted level, so any return to the old level (a
  // bounce) restarts the qualification window.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic              r_meta;
    logic              r_sync;
    logic              r_level;
    logic              r_level_d;
    logic [c_DB_W-1:0] r_cnt;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
        r_meta    <= 1'b0;
        r_sync    <= 1'b0;
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_meta    <= w_btn_raw[g];
        r_sync    <= r_meta;
        r_level_d <= r_level;
        if (r_sync == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_level <= r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[g] = r_level & ~r_level_d;
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t     r_state;
  logic [2:0] r_col;        // column latched for the move in progress
  logic [2:0] r_rd_row;
  logic [2:0] r_wr_row;
  logic       r_wr_en;
  logic       r_chk_start;
  logic [6:0] r_move_cnt;
  logic [2:0] r_cur_col;
  logic [1:0] r_player;
  logic       r_game_over;
  logic [1:0] r_winner;
  logic       r_busy;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_col       <= 3'd0;
      r_rd_row    <= 3'd0;
      r_wr_row    <= 3'd0;
      r_wr_en     <= 1'b0;
      r_chk_start <= 1'b0;
      r_move_cnt  <= 7'd0;
      r_cur_col   <= 3'd0;
      r_player    <= c_P1;
      r_game_over <= 1'b0;
      r_winner    <= 2'b00;
      r_busy      <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_chk_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Fixed priority: drop, then left, then right; losers are dropped.
          if (w_press[2]) begin
            r_col    <= r_cur_col;
            r_rd_row <= 3'd0;
            r_busy   <= 1'b1;
            r_state  <= S_SCAN;
          end else if (w_press[1]) begin
            if (r_cur_col != 3'd0) r_cur_col <= r_cur_col - 3'd1;
          end else if (w_press[0]) begin
            if (r_cur_col != c_LAST_COL) r_cur_col <= r_cur_col + 3'd1;
          end
        end
        S_SCAN: begin
          if (bus.rd_data == 2'b00) begin
            r_wr_row <= r_rd_row;
            r_wr_en  <= 1'b1;   // strobe is high for the single WRITE cycle
            r_state  <= S_WRITE;
          end else if (r_rd_row == c_LAST_ROW) begin
            r_busy  <= 1'b0;    // column full: move rejected
            r_state <= S_IDLE;
          end else begin
            r_rd_row <= r_rd_row + 3'd1;
          end
        end
        S_WRITE: begin
          r_chk_start <= 1'b1;  // high on the first CHECK cycle only
          if (r_move_cnt != c_CELLS) r_move_cnt <= r_move_cnt + 7'd1;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (bus.chk_done) begin
            if (bus.chk_win) begin
              r_winner    <= r_player;
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else if (r_move_cnt == c_CELLS) begin
              r_winner    <= 2'b00;
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_player <= (r_player == c_P1) ? c_P2 : c_P1;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        S_OVER: begin
          r_state <= S_OVER;    // only rst_n leaves
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_row    = r_rd_row;
  assign bus.rd_col    = r_col;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_row    = r_wr_row;
  assign bus.wr_col    = r_col;
  assign bus.wr_data   = r_player;
  assign bus.chk_start = r_chk_start;

  assign current_col    = r_cur_col;
  assign current_player = r_player;
  assign game_over      = r_game_over;
  assign winner         = r_winner;
  assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_connect_four_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_connect_four_move_ctrl
// Description : Self-checking bench for connect_four_move_ctrl. Provides a
//               board memory and a win-checker model on the bus; expected
//               board writes are queued when a drop is driven and compared
//               when the write strobe appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_connect_four_move_ctrl;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic       clk_25MHz = 1'b0;
  logic       rst_n;
  logic       move_right;
  logic       move_left;
  logic       drop_piece;
  logic [2:0] current_col;
  logic [1:0] current_player;
  logic       game_over;
  logic [1:0] winner;
  logic       busy;

  always #5 clk_25MHz = ~clk_25MHz;

  connect_four_move_ctrl_if bus ();

  connect_four_move_ctrl #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clk_25MHz      (clk_25MHz),
    .rst_n          (rst_n),
    .move_right     (move_right),
    .move_left      (move_left),
    .drop_piece     (drop_piece),
    .bus            (bus),
    .current_col    (current_col),
    .current_player (current_player),
    .game_over      (game_over),
    .winner         (winner),
    .busy           (busy)
  );

  // Board storage model, cleared by the same reset.
  logic [1:0] board [ROWS][COLS];
  always @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          board[r][c] <= 2'b00;
    end else if (bus.wr_en) begin
      board[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end
  assign bus.rd_data = board[bus.rd_row][bus.rd_col];

  // Win-checker model: answers cfg_lat cycles after chk_start.
  int cfg_lat = 2;
  bit cfg_win = 1'b0;
  int ck_cnt;
  bit ck_act;
  always @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      bus.chk_done <= 1'b0;
      bus.chk_win  <= 1'b0;
      ck_cnt       <= 0;
      ck_act       <= 1'b0;
    end else begin
      bus.chk_done <= 1'b0;
      bus.chk_win  <= 1'b0;
      if (bus.chk_start) begin
        ck_act <= 1'b1;
        ck_cnt <= cfg_lat;
      end else if (ck_act) begin
        if (ck_cnt <= 1) begin
          bus.chk_done <= 1'b1;
          bus.chk_win  <= cfg_win;
          ck_act       <= 1'b0;
        end else begin
          ck_cnt <= ck_cnt - 1;
        end
      end
    end
  end

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] data;
  } wr_t;

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;

  // Game model
  int         height[COLS];
  int         m_col;
  int         m_moves;
  logic [1:0] m_player;
  logic [1:0] m_winner;
  bit         m_over;

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) height[c] = 0;
    m_col = 0; m_moves = 0; m_player = 2'b01; m_winner = 2'b00; m_over = 1'b0;
    sb.delete();
  endtask

  task automatic apply_reset();
    move_right = 1'b0; move_left = 1'b0; drop_piece = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_25MHz);
  endtask

  // Press one button (0 right, 1 left, 2 drop) long enough to be accepted.
  task automatic press_btn(input int which, output int wr_seen, output int cs_seen);
    wr_seen = 0; cs_seen = 0;
    if (which == 0) move_right = 1'b1;
    else if (which == 1) move_left = 1'b1;
    else drop_piece = 1'b1;
    repeat (10) begin
      @(negedge clk_25MHz);
      if (bus.wr_en) wr_seen++;
      if (bus.chk_start) cs_seen++;
    end
    move_right = 1'b0; move_left = 1'b0; drop_piece = 1'b0;
    repeat (12) begin
      @(negedge clk_25MHz);
      if (bus.wr_en) wr_seen++;
      if (bus.chk_start) cs_seen++;
    end
  endtask

  task automatic move_cursor(input bit right);
    int wr_n, cs_n;
    press_btn(right ? 0 : 1, wr_n, cs_n);
    if (!m_over) begin
      if (right && m_col < COLS - 1) m_col++;
      if (!right && m_col > 0) m_col--;
    end
  endtask

  // One drop at the model cursor; checks write payload, latency and status.
  task automatic drop_move(input bit with_left, input bit win);
    wr_t exp_e, got_e;
    bit  exp_wr, done;
    int  r, w, wr_k, cs_k, wr_n, cs_n, blen;
    r      = height[m_col];
    exp_wr = (r < ROWS);
    cfg_win = win;
    if (exp_wr) begin
      exp_e.row = 3'(r); exp_e.col = 3'(m_col); exp_e.data = m_player;
      sb.push_back(exp_e);
    end
    drop_piece = 1'b1;
    move_left  = with_left;
    w = 0;
    while (busy !== 1'b1 && w < 40) begin
      @(negedge clk_25MHz);
      w++;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_start: busy=%b after %0d cycles, required 1", busy, w);
      drop_piece = 1'b0; move_left = 1'b0;
      repeat (12) @(negedge clk_25MHz);
      sb.delete();
      return;
    end
    // k = 0 is the first SCAN cycle (press pulse cycle + 1).
    wr_k = -1; cs_k = -1; wr_n = 0; cs_n = 0; blen = -1; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (k > 0) @(negedge clk_25MHz);
      if (bus.wr_en) begin
        wr_n++;
        if (wr_k < 0) wr_k = k;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: wr=(%0d,%0d,%b), required no write",
                   bus.wr_row, bus.wr_col, bus.wr_data);
        end else begin
          got_e = sb.pop_front();
          if ({bus.wr_row, bus.wr_col, bus.wr_data} !== got_e) begin
            errors++;
            $display("FAIL wr_payload: got (%0d,%0d,%b), required (%0d,%0d,%b)",
                     bus.wr_row, bus.wr_col, bus.wr_data, got_e.row, got_e.col, got_e.data);
          end
        end
      end
      if (bus.chk_start) begin
        cs_n++;
        if (cs_k < 0) cs_k = k;
      end
      if (busy !== 1'b1) begin
        blen = k; done = 1'b1;
      end else if (game_over === 1'b1) begin
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drop_end: move never completed, busy=%b game_over=%b", busy, game_over);
    end
    if (exp_wr) begin
      checks++;
      if (wr_n != 1 || wr_k != 1 + r) begin
        errors++;
        $display("FAIL wr_timing: %0d strobes at k=%0d, required 1 at k=%0d", wr_n, wr_k, 1 + r);
      end
      checks++;
      if (cs_n != 1 || cs_k != 2 + r) begin
        errors++;
        $display("FAIL chk_start_timing: %0d pulses at k=%0d, required 1 at k=%0d", cs_n, cs_k, 2 + r);
      end
    end else begin
      checks++;
      if (wr_n != 0 || cs_n != 0) begin
        errors++;
        $display("FAIL full_col: wr_en=%0d chk_start=%0d, required 0 and 0", wr_n, cs_n);
      end
      checks++;
      if (blen != 8) begin
        errors++;
        $display("FAIL full_busy: busy high %0d cycles after SCAN start, required 8", blen);
      end
    end
    drop_piece = 1'b0; move_left = 1'b0;
    repeat (12) @(negedge clk_25MHz);
    if (exp_wr) begin
      height[m_col]++;
      m_moves++;
      if (win) begin
        m_over = 1'b1; m_winner = m_player;
      end else if (m_moves == ROWS * COLS) begin
        m_over = 1'b1; m_winner = 2'b00;
      end else begin
        m_player = (m_player == 2'b01) ? 2'b10 : 2'b01;
      end
    end
    checks++;
    if ({current_player, game_over, winner, current_col} !==
        {m_player, m_over, m_winner, 3'(m_col)}) begin
      errors++;
      $display("FAIL status: player=%b over=%b winner=%b col=%0d, required %b %b %b %0d",
               current_player, game_over, winner, current_col, m_player, m_over, m_winner, m_col);
    end
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    move_right = 1'b0; move_left = 1'b0; drop_piece = 1'b0;
    rst_n = 1'b0;
    #1;
    obs = {current_col, current_player, game_over, winner, bus.wr_en, bus.chk_start, busy, bus.rd_row};
    checks++;
    if (obs !== 14'b000_01_0_00_0_0_0_000) begin
      errors++;
      $display("FAIL reset_values: got %b, required %b", obs, 14'b000_01_0_00_0_0_0_000);
    end
    repeat (3) @(negedge clk_25MHz);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_25MHz);
  endtask

  task automatic test_cursor();
    repeat (3) move_cursor(1'b1);
    checks++;
    if (current_col !== 3'(m_col) || m_col != 3) begin
      errors++;
      $display("FAIL cursor_right3: col=%0d, required 3", current_col);
    end
    repeat (5) move_cursor(1'b0);
    checks++;
    if (current_col !== 3'(m_col) || m_col != 0) begin
      errors++;
      $display("FAIL cursor_left_sat: col=%0d, required 0", current_col);
    end
    repeat (10) move_cursor(1'b1);
    checks++;
    if (current_col !== 3'(m_col) || m_col != 7) begin
      errors++;
      $display("FAIL cursor_right_sat: col=%0d, required 7", current_col);
    end
  endtask

  task automatic test_drop_stack();
    apply_reset();
    repeat (2) move_cursor(1'b1);
    repeat (3) drop_move(1'b0, 1'b0);
    checks++;
    if (current_player !== 2'b10) begin
      errors++;
      $display("FAIL stack_player: player=%b, required 10", current_player);
    end
  endtask

  task automatic test_full_column();
    repeat (3) move_cursor(1'b1);
    repeat (8) drop_move(1'b0, 1'b0);
    drop_move(1'b0, 1'b0);   // ninth drop into the full column
  endtask

  task automatic test_reset_mid_op();
    logic [13:0] obs;
    int w;
    // Column 5 is full, so the sequencer spends 8 cycles in SCAN.
    drop_piece = 1'b1;
    w = 0;
    while (busy !== 1'b1 && w < 40) begin @(negedge clk_25MHz); w++; end
    repeat (3) @(negedge clk_25MHz);
    #2 rst_n = 1'b0;
    #1;
    obs = {current_col, current_player, game_over, winner, bus.wr_en, bus.chk_start, busy, bus.rd_row};
    checks++;
    if (obs !== 14'b000_01_0_00_0_0_0_000) begin
      errors++;
      $display("FAIL reset_mid_scan: got %b, required %b", obs, 14'b000_01_0_00_0_0_0_000);
    end
    drop_piece = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_25MHz);
    // Reset while the write strobe is high.
    drop_piece = 1'b1;
    w = 0;
    while (busy !== 1'b1 && w < 40) begin @(negedge clk_25MHz); w++; end
    @(negedge clk_25MHz);
    checks++;
    if (bus.wr_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_wr: wr_en=%b, required 1", bus.wr_en);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wr_en, bus.chk_start, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_write: wr_en/chk_start/busy=%b, required 000",
               {bus.wr_en, bus.chk_start, busy});
    end
    drop_piece = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    rst_n = 1'b1;
    model_reset();
    repeat (12) @(negedge clk_25MHz);
  endtask

  task automatic test_win();
    int wr_n, cs_n, wr_t_n, cs_t_n;
    apply_reset();
    cfg_lat = 6;
    // P1 stacks column 0, P2 column 1; the seventh move is P1's fourth.
    for (int i = 0; i < 7; i++) begin
      drop_move(1'b0, i == 6);
      if (i < 6) move_cursor((i % 2) == 0);
    end
    checks++;
    if ({game_over, winner} !== 3'b1_01) begin
      errors++;
      $display("FAIL win: over=%b winner=%b, required 1 01", game_over, winner);
    end
    wr_t_n = 0; cs_t_n = 0;
    press_btn(0, wr_n, cs_n); wr_t_n += wr_n; cs_t_n += cs_n;
    press_btn(2, wr_n, cs_n); wr_t_n += wr_n; cs_t_n += cs_n;
    press_btn(1, wr_n, cs_n); wr_t_n += wr_n; cs_t_n += cs_n;
    checks++;
    if ({current_col, game_over, winner, current_player, busy} !== {3'(m_col), 1'b1, 2'b01, 2'b01, 1'b1}
        || wr_t_n != 0 || cs_t_n != 0) begin
      errors++;
      $display("FAIL over_ignores: col=%0d over=%b winner=%b player=%b busy=%b wr=%0d cs=%0d, required %0d 1 01 01 1 0 0",
               current_col, game_over, winner, current_player, busy, wr_t_n, cs_t_n, m_col);
    end
    cfg_lat = 2;
  endtask

  task automatic test_glitch_arb();
    apply_reset();
    move_right = 1'b1;
    repeat (2) @(negedge clk_25MHz);
    move_right = 1'b0;
    repeat (15) @(negedge clk_25MHz);
    checks++;
    if ({current_col, busy} !== 4'b000_0) begin
      errors++;
      $display("FAIL glitch: col=%0d busy=%b, required 0 0", current_col, busy);
    end
    repeat (3) move_cursor(1'b1);
    drop_move(1'b1, 1'b0);   // drop and left together: only the drop acts
  endtask

  task automatic test_draw();
    apply_reset();
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) drop_move(1'b0, 1'b0);
      if (c < COLS - 1) move_cursor(1'b1);
    end
    checks++;
    if ({game_over, winner} !== 3'b1_00) begin
      errors++;
      $display("FAIL draw: over=%b winner=%b, required 1 00", game_over, winner);
    end
  endtask

  initial begin
    move_right = 1'b0; move_left = 1'b0; drop_piece = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_25MHz);
    test_reset();
    test_cursor();
    test_drop_stack();
    test_full_column();
    test_reset_mid_op();
    test_win();
    test_glitch_arb();
    test_draw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
